// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the timing generator and the display logic.
package vga_pkg;

  // Sum of the four segments of one line or one frame.
  function automatic int unsigned seg_total(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // True when v lies in the half-open window [lo, hi).
  function automatic logic in_window(input logic [31:0] v, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  localparam int unsigned CLK_DIV_DEF = 2;

  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;

  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned H_TOT_DEF = seg_total(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOT_DEF = seg_total(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Sync pulses occupy [START, END) in pixel / line coordinates.
  localparam int unsigned H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_if.sv
// Raster position, sync and strobe bundle produced by vga_timing.
// Strobes: pix_tick and frame_start are single-CLK pulses; there is no
// back-pressure, consumers sample every CLK.
interface vga_timing_if;
  logic [31:0] row;
  logic [31:0] col;
  logic        vnotactive;
  logic        hsync;
  logic        vsync;
  logic        pix_tick;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    output row, col, vnotactive, hsync, vsync, pix_tick, frame_start, frame_cnt
  );

  modport slave (
    input row, col, vnotactive, hsync, vsync, pix_tick, frame_start, frame_cnt
  );
endinterface

// File: rtl/pix_tick_gen.sv
// Pixel-rate prescaler: tick is high on the CLK cycle where the count is CLK_DIV-1.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 and wrap; with CLK_DIV=1 the count sits at 0 so tick stays high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters with registered position, blanking and sync outputs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned H_VIS   = H_VIS_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_VIS   = V_VIS_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF
) (
  input logic          CLK,
  input logic          RST,
  vga_timing_if.master vga
);
  localparam int unsigned H_TOT = seg_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = seg_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [31:0] H_LAST = 32'(H_TOT - 1);
  localparam logic [31:0] V_LAST = 32'(V_TOT - 1);
  localparam logic [31:0] HS_LO  = 32'(H_VIS + H_FP);
  localparam logic [31:0] HS_HI  = 32'(H_VIS + H_FP + H_SYNC);
  localparam logic [31:0] VS_LO  = 32'(V_VIS + V_FP);
  localparam logic [31:0] VS_HI  = 32'(V_VIS + V_FP + V_SYNC);
  localparam logic [31:0] H_VIS_W = 32'(H_VIS);
  localparam logic [31:0] V_VIS_W = 32'(V_VIS);

  logic        tick;
  logic [31:0] hcnt;
  logic [31:0] vcnt;
  logic [31:0] hcnt_nxt;
  logic [31:0] vcnt_nxt;
  logic        frame_wrap;
  logic        vna_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;
  logic [7:0]  fcnt_q;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Next counter values: advance only on a pixel tick, line wrap carries into the row.
  always_comb begin
    hcnt_nxt   = hcnt;
    vcnt_nxt   = vcnt;
    frame_wrap = 1'b0;
    if (tick) begin
      if (hcnt == H_LAST) begin
        hcnt_nxt = '0;
        if (vcnt == V_LAST) begin
          vcnt_nxt   = '0;
          frame_wrap = 1'b1;
        end else begin
          vcnt_nxt = vcnt + 32'd1;
        end
      end else begin
        hcnt_nxt = hcnt + 32'd1;
      end
    end
  end

  // Counters and decoded outputs register together so the ports always agree with row/col.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt   <= '0;
      vcnt   <= '0;
      vna_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
      vna_q <= (hcnt_nxt >= H_VIS_W) || (vcnt_nxt >= V_VIS_W);
      hs_q  <= !in_window(hcnt_nxt, HS_LO, HS_HI);
      vs_q  <= !in_window(vcnt_nxt, VS_LO, VS_HI);
      fs_q  <= frame_wrap;
      if (frame_wrap) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  assign vga.row         = vcnt;
  assign vga.col         = hcnt;
  assign vga.vnotactive  = vna_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.pix_tick    = tick;
  assign vga.frame_start = fs_q;
  assign vga.frame_cnt   = fcnt_q;
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter CLK_DIV, default 2, CLK cycles per pixel (1 = one pixel every CLK).
REQ-002 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 row  output  32  current line index (vcnt), zero-extended.
REQ-007 col  output  32  current pixel index in line (hcnt), zero-extended.
REQ-008 vnotactive  output  1  high when (col,row) is outside the visible area.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low.
REQ-011 pix_tick  output  1  one-CLK strobe marking each pixel advance.
REQ-012 frame_start  output  1  one-CLK strobe when counters wrap to (0,0).
REQ-013 frame_cnt  output  8  completed-frame counter.

Function
REQ-014 Prescaler counts 0..CLK_DIV-1 and asserts pix_tick on the CLK cycle where the count equals CLK_DIV-1; with CLK_DIV=1, pix_tick is constantly high after reset.
REQ-015 hcnt and vcnt change only on a CLK edge where pix_tick is high; otherwise they hold.
REQ-016 On a tick, hcnt increments; at H_TOT-1 (H_TOT=H_VIS+H_FP+H_SYNC+H_BP=800) it wraps to 0 and vcnt increments.
REQ-017 vcnt wraps from V_TOT-1 (V_TOT=525) to 0 only when hcnt also wraps.
REQ-018 row, col, vnotactive, hsync and vsync are registered and update on the same CLK edge as the counters; no combinational path from counters to ports.
REQ-019 vnotactive = (hcnt >= H_VIS) or (vcnt >= V_VIS), evaluated on the updated counter values.
REQ-020 hsync is low iff H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751 at defaults).
REQ-021 vsync is low iff V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC (490..491 at defaults).
REQ-022 frame_start is high for exactly the one CLK cycle following the edge on which both counters wrap to 0.
REQ-023 frame_cnt increments by one on each frame_start, modulo 256 (255 -> 0).
REQ-024 Frame length is H_TOT*V_TOT*CLK_DIV CLK cycles (840000 at defaults).

Reset
REQ-025 RST high at a CLK edge forces prescaler=0, hcnt=0, vcnt=0, row=0, col=0, vnotactive=0, hsync=1, vsync=1, pix_tick=0 (1 if CLK_DIV=1), frame_start=0, frame_cnt=0.
REQ-026 RST has priority over every tick, including mid-line, mid-sync and at wrap points; the first tick after RST release advances col to 1.
REQ-027 Reset does not generate frame_start.

Structure
REQ-028 Timing defaults, H_TOT/V_TOT and sync window bounds are constants in shared package vga_pkg; the display logic uses the same package.
REQ-029 Prescaler is sub-module pix_tick_gen (CLK, RST, tick); the counters and decode stay in vga_timing.

Verification
REQ-030 CLK_DIV=2, release RST -> pix_tick every 2nd CLK; col 0,1,2... advancing every 2 CLK; row=0; vnotactive=0.
REQ-031 Run to col 639 -> next tick col=640 with vnotactive=1; hsync low exactly for col 656..751; col 799 -> col=0, row=1, vnotactive=0.
REQ-032 Run to row=524, col=799 -> next tick row=0, col=0, frame_start high one CLK, frame_cnt 0->1; vsync low exactly for rows 490..491.
REQ-033 Assert RST for one CLK at row=300, col=400 -> next cycle row=0, col=0, hsync=vsync=1, frame_cnt=0, no frame_start.
REQ-034 CLK_DIV=1, run 256 frames -> pix_tick constantly high, each frame 420000 CLK, frame_cnt wraps 255->0.
